// File: rtl/fetch_sequencer.sv
// Program-counter controller feeding the IF stage: boot, linear fetch, stall
// hold, branch redirect with bubble insertion and flush, halt/resume, plus a
// debug counter of retired (advancing, valid) fetches.
module fetch_sequencer #(
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP        = PC_WIDTH'(1),
  parameter int                  BRANCH_BUBBLES = 1   // legal range 1..7
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic                BR_TAKEN,
  input  logic [PC_WIDTH-1:0] BR_TARGET,
  input  logic                HALT_REQ,
  input  logic                RESUME,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PC_NEXT,
  output logic                FETCH_VALID,
  output logic                FLUSH,
  output logic                HALTED,
  output logic [31:0]         FETCH_COUNT
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIRECT,
    S_HALT
  } state_t;

  // The redirect state lasts BRANCH_BUBBLES cycles; the counter counts down
  // to zero and the cycle that reads zero is the last bubble.
  localparam logic [2:0] BUBBLE_RELOAD = 3'(BRANCH_BUBBLES - 1);

  state_t     state;
  logic [2:0] bubble_cnt;

  // Sequential successor address; wraps modulo 2^PC_WIDTH with no flag.
  assign PC_NEXT = PC + PC_STEP;

  // Single FSM: state, PC, bubble counter and all registered outputs.
  always_ff @(posedge CLOCK) begin
    // NOTE: non-blocking assignments keep every register here reading the
    // pre-edge values of the others, so evaluation order inside the block
    // cannot change the result.
    if (RESET) begin
      state       <= S_BOOT;
      bubble_cnt  <= '0;
      PC          <= RESET_VECTOR;
      FETCH_VALID <= 1'b0;
      FLUSH       <= 1'b0;
      HALTED      <= 1'b0;
      FETCH_COUNT <= '0;
    end else begin
      // FLUSH is a one-cycle pulse; only a taken branch raises it again.
      FLUSH <= 1'b0;
      case (state)
        S_BOOT: begin
          state       <= S_RUN;
          FETCH_VALID <= 1'b1;
        end

        S_RUN: begin
          if (BR_TAKEN) begin
            state       <= S_REDIRECT;
            PC          <= BR_TARGET;
            FETCH_VALID <= 1'b0;
            FLUSH       <= 1'b1;
            bubble_cnt  <= BUBBLE_RELOAD;
          end else if (HALT_REQ) begin
            // The halt instruction itself retires, so it is counted.
            state       <= S_HALT;
            PC          <= PC_NEXT;
            FETCH_VALID <= 1'b0;
            HALTED      <= 1'b1;
            FETCH_COUNT <= FETCH_COUNT + 32'd1;
          end else if (!STALL) begin
            PC          <= PC_NEXT;
            FETCH_COUNT <= FETCH_COUNT + 32'd1;
          end
        end

        S_REDIRECT: begin
          // A newer taken branch replaces the pending redirect outright.
          if (BR_TAKEN) begin
            PC         <= BR_TARGET;
            FLUSH      <= 1'b1;
            bubble_cnt <= BUBBLE_RELOAD;
          end else if (bubble_cnt == 3'd0) begin
            state       <= S_RUN;
            FETCH_VALID <= 1'b1;
          end else begin
            bubble_cnt <= bubble_cnt - 3'd1;
          end
        end

        S_HALT: begin
          if (RESUME) begin
            state       <= S_RUN;
            FETCH_VALID <= 1'b1;
            HALTED      <= 1'b0;
          end
        end

        default: begin
          state       <= S_BOOT;
          FETCH_VALID <= 1'b0;
          HALTED      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with BRANCH_BUBBLES=2: a table of
// per-cycle inputs and expected registered outputs, then hand-written
// sequences for PC wrap-around and reset in the middle of a redirect/halt.
module tb_fetch_sequencer;

  logic        CLOCK;
  logic        RESET;
  logic        STALL;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        HALT_REQ;
  logic        RESUME;
  logic [31:0] PC;
  logic [31:0] PC_NEXT;
  logic        FETCH_VALID;
  logic        FLUSH;
  logic        HALTED;
  logic [31:0] FETCH_COUNT;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .PC_WIDTH      (32),
    .RESET_VECTOR  (32'h0000_0000),
    .PC_STEP       (32'd1),
    .BRANCH_BUBBLES(2)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .STALL      (STALL),
    .BR_TAKEN   (BR_TAKEN),
    .BR_TARGET  (BR_TARGET),
    .HALT_REQ   (HALT_REQ),
    .RESUME     (RESUME),
    .PC         (PC),
    .PC_NEXT    (PC_NEXT),
    .FETCH_VALID(FETCH_VALID),
    .FLUSH      (FLUSH),
    .HALTED     (HALTED),
    .FETCH_COUNT(FETCH_COUNT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        hl;
    logic [31:0] cnt;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] tgt,
                              logic halt, logic resume, logic [31:0] pc,
                              logic fv, logic fl, logic hl, logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt;
    v.halt = halt; v.resume = resume;
    v.pc = pc; v.fv = fv; v.fl = fl; v.hl = hl; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic br,
                       input logic [31:0] tgt, input logic halt, input logic resume);
    RESET     = rst;
    STALL     = stall;
    BR_TAKEN  = br;
    BR_TARGET = tgt;
    HALT_REQ  = halt;
    RESUME    = resume;
  endtask

  // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic step(input logic rst, input logic stall, input logic br,
                      input logic [31:0] tgt, input logic halt, input logic resume);
    drive(rst, stall, br, tgt, halt, resume);
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic fv,
                           input logic fl, input logic hl, input logic [31:0] cnt);
    check({tag, " pc"},      PC,                  pc);
    check({tag, " pc_next"}, PC_NEXT,             pc + 32'd1);
    check({tag, " valid"},   {31'd0, FETCH_VALID}, {31'd0, fv});
    check({tag, " flush"},   {31'd0, FLUSH},       {31'd0, fl});
    check({tag, " halted"},  {31'd0, HALTED},      {31'd0, hl});
    check({tag, " count"},   FETCH_COUNT,         cnt);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //                 rst stall br  tgt           halt res  pc            fv   fl   hl   cnt
    // Boot and linear fetch; row 1 leaves the DUT in BOOT (valid low).
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'd0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h1,       1'b1, 1'b0, 1'b0, 32'd1);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h2,       1'b1, 1'b0, 1'b0, 32'd2);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h3,       1'b1, 1'b0, 1'b0, 32'd3);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h4,       1'b1, 1'b0, 1'b0, 32'd4);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h5,       1'b1, 1'b0, 1'b0, 32'd5);
    // Stall three cycles at PC=5.
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h5,       1'b1, 1'b0, 1'b0, 32'd5);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h5,       1'b1, 1'b0, 1'b0, 32'd5);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h5,       1'b1, 1'b0, 1'b0, 32'd5);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h6,       1'b1, 1'b0, 1'b0, 32'd6);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h7,       1'b1, 1'b0, 1'b0, 32'd7);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h8,       1'b1, 1'b0, 1'b0, 32'd8);
    // Branch at PC=8 to 0x40, two bubbles.
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h40,      1'b0, 1'b1, 1'b0, 32'd8);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h40,      1'b0, 1'b0, 1'b0, 32'd8);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h40,      1'b1, 1'b0, 1'b0, 32'd8);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h41,      1'b1, 1'b0, 1'b0, 32'd9);
    // Branch to 0x40, then re-branch to 0x80 during the bubble.
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 32'h40,      1'b0, 1'b1, 1'b0, 32'd9);
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 32'h80,      1'b0, 1'b0, 32'h80,      1'b0, 1'b1, 1'b0, 32'd9);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h80,      1'b0, 1'b0, 1'b0, 32'd9);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h80,      1'b1, 1'b0, 1'b0, 32'd9);
    vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h81,      1'b1, 1'b0, 1'b0, 32'd10);
    // STALL and BR_TAKEN together: branch wins; STALL/HALT_REQ ignored in redirect.
    vecs[23] = mk(1'b0, 1'b1, 1'b1, 32'h10,      1'b0, 1'b0, 32'h10,      1'b0, 1'b1, 1'b0, 32'd10);
    vecs[24] = mk(1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h10,      1'b0, 1'b0, 1'b0, 32'd10);
    vecs[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h10,      1'b1, 1'b0, 1'b0, 32'd10);
    // Halt at 0x10; branch, stall and halt requests ignored while halted.
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h11,      1'b0, 1'b0, 1'b1, 32'd11);
    vecs[27] = mk(1'b0, 1'b1, 1'b1, 32'h99,      1'b0, 1'b0, 32'h11,      1'b0, 1'b0, 1'b1, 32'd11);
    vecs[28] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h11,      1'b0, 1'b0, 1'b1, 32'd11);
    vecs[29] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h11,      1'b1, 1'b0, 1'b0, 32'd11);
    vecs[30] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h12,      1'b1, 1'b0, 1'b0, 32'd12);
    // HALT_REQ and BR_TAKEN together in RUN: branch wins.
    vecs[31] = mk(1'b0, 1'b0, 1'b1, 32'h20,      1'b1, 1'b0, 32'h20,      1'b0, 1'b1, 1'b0, 32'd12);
    vecs[32] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h20,      1'b0, 1'b0, 1'b0, 32'd12);
    vecs[33] = mk(1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h20,      1'b1, 1'b0, 1'b0, 32'd12);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].halt, vecs[i].resume);
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fv, vecs[i].fl,
                vecs[i].hl, vecs[i].cnt);
    end

    // Wrap-around: branch to all-ones, wait out the bubbles, then advance.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_all("wrap_br", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'd12);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_all("wrap_top", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd12);
    check("wrap_pc_next_zero", PC_NEXT, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_all("wrap_zero", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd13);

    // Reset during REDIRECT: reset values next cycle, no FLUSH afterwards.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    check_all("rd_br", 32'h40, 1'b0, 1'b1, 1'b0, 32'd13);
    step(1'b1, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    check_all("rd_reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h77, 1'b1, 1'b0);
    check_all("rd_boot_exit", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_all("rd_run", 32'h1, 1'b1, 1'b0, 1'b0, 32'd1);

    // Reset from HALT discards the halt.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_all("hr_halt", 32'h2, 1'b0, 1'b0, 1'b1, 32'd2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_all("hr_reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_all("hr_boot_exit", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
